// File: rtl/bit_unpacker.sv
// Bit unpacker: accepts 32-bit packed words and hands out LSB-first fields of
// 0..32 bits from a 64-bit staging buffer, undoing the entropy-coder packer.
module bit_unpacker (
    input  logic        clock,
    input  logic        nreset,
    input  logic        word_in_valid,
    input  logic [31:0] word_in,
    output logic        word_in_ready,
    input  logic        req_valid,
    input  logic [5:0]  req_length,
    output logic        req_ready,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic [31:0] peek_data,
    output logic [6:0]  bits_available
);

    logic [63:0] stage_buf;
    logic [6:0]  count;

    logic        req_fire;
    logic        word_fire;
    logic [5:0]  take_len;
    logic [6:0]  remain;
    logic [63:0] shifted;
    logic [63:0] placed;
    logic [63:0] buf_next;
    logic [6:0]  count_next;
    logic [31:0] field_mask;
    logic [31:0] field;

    // Handshakes look only at registered state; an arriving word is never bypassed.
    assign word_in_ready  = (count <= 7'd32);
    assign req_ready      = req_valid && (req_length <= 6'd32) && (count >= {1'b0, req_length});
    assign req_fire       = req_ready;
    assign word_fire      = word_in_valid && word_in_ready;

    assign peek_data      = stage_buf[31:0];
    assign bits_available = count;

    always_comb begin
        take_len   = 6'd0;
        field_mask = 32'd0;
        if (req_fire) begin
            take_len = req_length;
        end
        if (take_len == 6'd32) begin
            field_mask = 32'hFFFF_FFFF;
        end else begin
            field_mask = (32'd1 << take_len) - 32'd1;
        end
        field = stage_buf[31:0] & field_mask;
    end

    // The new word lands directly above whatever survives this cycle's shift.
    always_comb begin
        remain     = count - {1'b0, take_len};
        shifted    = stage_buf >> take_len;
        placed     = {32'd0, word_in} << remain;
        buf_next   = shifted;
        count_next = remain;
        if (word_fire) begin
            buf_next   = shifted | placed;
            count_next = remain + 7'd32;
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            stage_buf      <= 64'd0;
            count          <= 7'd0;
            data_out       <= 32'd0;
            data_out_valid <= 1'b0;
        end else begin
            stage_buf      <= buf_next;
            count          <= count_next;
            data_out_valid <= req_fire;
            if (req_fire) begin
                data_out <= field;
            end
        end
    end

    // Bits above the fill level must always be zero so peek_data is zero-filled.
    assert property (@(posedge clock) disable iff (nreset) (stage_buf >> count) == 64'd0);
    assert property (@(posedge clock) disable iff (nreset) count <= 7'd64);

`ifdef FORMAL
    assume property (@(posedge clock) req_valid |-> req_length <= 6'd32);
`endif

endmodule

// File: tb/tb_bit_unpacker.sv
// Scoreboard bench for bit_unpacker: directed words/requests push expected
// fields into a queue; a negedge monitor pops and compares each data_out pulse.
module tb_bit_unpacker;

    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic        word_in_valid = 1'b0;
    logic [31:0] word_in = 32'd0;
    logic        word_in_ready;
    logic        req_valid = 1'b0;
    logic [5:0]  req_length = 6'd0;
    logic        req_ready;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic [31:0] peek_data;
    logic [6:0]  bits_available;

    int checks = 0;
    int failures = 0;
    logic [31:0] expected_q[$];

    bit_unpacker dut (
        .clock          (clock),
        .nreset         (nreset),
        .word_in_valid  (word_in_valid),
        .word_in        (word_in),
        .word_in_ready  (word_in_ready),
        .req_valid      (req_valid),
        .req_length     (req_length),
        .req_ready      (req_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .peek_data      (peek_data),
        .bits_available (bits_available)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Drive one cycle of stimulus; an expected accept queues the field it must produce.
    task automatic applyStimulus(input logic wv, input logic [31:0] w, input logic rv,
                                 input logic [5:0] rl, input logic expect_accept,
                                 input logic [31:0] expect_data);
        word_in_valid = wv;
        word_in       = w;
        req_valid     = rv;
        req_length    = rl;
        #1;
        if (rv) begin
            checkOutput("req_ready", {63'd0, req_ready}, {63'd0, expect_accept});
        end
        if (expect_accept) begin
            expected_q.push_back(expect_data);
        end
        @(posedge clock);
        #1;
        word_in_valid = 1'b0;
        req_valid     = 1'b0;
        req_length    = 6'd0;
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_out_valid) begin
            if (expected_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse actual=0x%0h required=none", data_out);
            end else begin
                checkOutput("data_out", {32'd0, data_out}, {32'd0, expected_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset held for two edges
        nreset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b0;
        checkOutput("reset_data_out", {32'd0, data_out}, 64'd0);
        checkOutput("reset_valid", {63'd0, data_out_valid}, 64'd0);
        checkOutput("reset_bits", {57'd0, bits_available}, 64'd0);
        checkOutput("reset_word_ready", {63'd0, word_in_ready}, 64'd1);
        checkOutput("reset_peek", {32'd0, peek_data}, 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd1, 1'b0, 32'd0);
        checkOutput("empty_bits", {57'd0, bits_available}, 64'd0);

        // Single word, three back-to-back fields
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0, 32'd0);
        checkOutput("single_bits32", {57'd0, bits_available}, 64'd32);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd4, 1'b1, 32'hF);
        checkOutput("single_bits28", {57'd0, bits_available}, 64'd28);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd8, 1'b1, 32'hEE);
        checkOutput("single_bits20", {57'd0, bits_available}, 64'd20);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd20, 1'b1, 32'hDEADB);
        checkOutput("single_bits0", {57'd0, bits_available}, 64'd0);

        // Field straddling two words
        applyStimulus(1'b1, 32'h12345678, 1'b0, 6'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 32'h9ABCDEF0, 1'b0, 6'd0, 1'b0, 32'd0);
        checkOutput("straddle_bits64", {57'd0, bits_available}, 64'd64);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd24, 1'b1, 32'h345678);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd16, 1'b1, 32'hF012);
        checkOutput("straddle_bits24", {57'd0, bits_available}, 64'd24);
        checkOutput("straddle_peek", {32'd0, peek_data}, 64'h9ABCDE);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd24, 1'b1, 32'h9ABCDE);

        // Simultaneous word and full-width request
        applyStimulus(1'b1, 32'hAAAAAAAA, 1'b0, 6'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 32'h55555555, 1'b1, 6'd32, 1'b1, 32'hAAAAAAAA);
        checkOutput("simul_bits", {57'd0, bits_available}, 64'd32);
        checkOutput("simul_peek", {32'd0, peek_data}, 64'h55555555);

        // Backpressure at a full buffer
        applyStimulus(1'b1, 32'h13579BDF, 1'b0, 6'd0, 1'b0, 32'd0);
        checkOutput("full_word_ready", {63'd0, word_in_ready}, 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd32, 1'b1, 32'h55555555);
        checkOutput("drain_word_ready", {63'd0, word_in_ready}, 64'd1);
        checkOutput("drain_bits", {57'd0, bits_available}, 64'd32);
        checkOutput("drain_peek", {32'd0, peek_data}, 64'h13579BDF);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd32, 1'b1, 32'h13579BDF);

        // Zero-length request on an empty buffer
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd0, 1'b1, 32'd0);
        checkOutput("zero_len_bits", {57'd0, bits_available}, 64'd0);

        // Build 40 buffered bits, then an illegal length must leave them intact
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b0, 6'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 32'h00000012, 1'b0, 6'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd24, 1'b1, 32'hFEF00D);
        checkOutput("pre_illegal_bits", {57'd0, bits_available}, 64'd40);
        applyStimulus(1'b0, 32'd0, 1'b1, 6'd40, 1'b0, 32'd0);
        checkOutput("illegal_bits", {57'd0, bits_available}, 64'd40);
        checkOutput("illegal_peek", {32'd0, peek_data}, 64'h12CA);
        checkOutput("hold_data_out", {32'd0, data_out}, 64'hFEF00D);
        checkOutput("hold_valid", {63'd0, data_out_valid}, 64'd0);

        // Mid-operation reset discards buffered bits
        nreset = 1'b1;
        @(posedge clock);
        #1;
        nreset = 1'b0;
        checkOutput("midreset_bits", {57'd0, bits_available}, 64'd0);
        checkOutput("midreset_peek", {32'd0, peek_data}, 64'd0);
        checkOutput("midreset_data_out", {32'd0, data_out}, 64'd0);
        checkOutput("midreset_word_ready", {63'd0, word_in_ready}, 64'd1);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("scoreboard_empty", {32'd0, expected_q.size()}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_unpacker.md
# bit_unpacker

Inverse of the entropy-coder bit packer. Accepts a stream of 32-bit words and hands out variable-length fields (0–32 bits) on request, LSB-first, exactly undoing the packer's alignment. It sits between the compressed-word memory reader and the Huffman/VLC decoder. A 64-bit staging buffer lets a field straddle two input words without stalling.

## Interface
Parameters: none.

- clock  in  1  system clock, all state on rising edge
- nreset  in  1  synchronous, active-high reset (reset asserted when nreset=1)
- word_in_valid  in  1  word_in holds a packed word
- word_in  in  32  packed word; bit 0 is the earliest stream bit
- word_in_ready  out  1  buffer can take a word this cycle
- req_valid  in  1  consumer requests req_length bits
- req_length  in  6  field width, 0..32; 33..63 are illegal
- req_ready  out  1  request accepted this cycle
- data_out  out  32  extracted field, right-aligned, upper bits zero
- data_out_valid  out  1  one-cycle pulse, data_out is valid
- peek_data  out  32  low 32 buffer bits, unconsumed and zero-filled (Huffman lookahead)
- bits_available  out  7  valid bits in buffer, 0..64

## Operation
- State: buf[63:0] and count[6:0]. Invariant: buf bits at or above count are zero (formal assert).
- word_in_ready = (count <= 32). Combinational from registered state only.
- req_ready = req_valid && req_length <= 32 && count >= req_length. Uses the current count only; a word arriving this cycle is not bypassed.
- Accept on a request (len L):
  - data_out <= buf[31:0] & ((1<<L)-1).
  - data_out_valid <= 1.
  - buf shifts right by L, zero-filled.
- Accept on a word: word_in is ORed into buf at bit position (count − L_accepted), where L_accepted = 0 if no request is accepted.
- count_next = count − L_accepted + (32 if word accepted else 0). Maximum 64; no overflow is possible because a word is taken only when count <= 32.
- L=0 request: always accepted, including at count=0. data_out=0 and data_out_valid pulses.
- Illegal length (>32): never accepted, with req_ready=0. A formal assume forbids it; the bench only checks that state is unchanged.
- No accepted request: data_out holds its last value and data_out_valid=0.
- peek_data = buf[31:0]. bits_available = count. Both are combinational from registers.

## Timing
- Reset (nreset=1 at an edge):
  - buf=0, count=0, data_out=0, data_out_valid=0.
  - Resulting outputs: word_in_ready=1, req_ready=0 for L>0, peek_data=0, bits_available=0.
- Reset mid-operation discards all buffered bits. An in-flight data_out_valid is cleared in the same edge.
- Request latency: accepted at edge N, so data_out/data_out_valid are valid after edge N, for exactly one cycle.
- Throughput: one request per cycle while count >= L. One word per cycle while count <= 32.
- Word latency: a word accepted at edge N is visible in peek_data/bits_available after edge N. It can satisfy a request at edge N+1.
- Simultaneous word and request in the same cycle are both accepted. The new word lands above the post-shift remainder.
- Full (count 33..64): word_in_ready=0. Empty (count=0): only L=0 requests are accepted.

## Test plan
- Reset: hold nreset=1 for 2 cycles, then release. Required: data_out=0, data_out_valid=0, bits_available=0, word_in_ready=1, and a req_length=1 request is not accepted.
- Single word: push 0xDEADBEEF, then request 4, 8, 20 in back-to-back cycles. Required: data_out=0xF, 0xEE, 0xDEADB; bits_available goes 32, 28, 20, 0.
- Straddle: push 0x12345678 then 0x9ABCDEF0, then request 24 and 16. Required: 0x345678 then 0xF012; bits_available=24 afterwards.
- Simultaneous: start at count=32 holding 0xAAAAAAAA. In one cycle, push 0x55555555 and request 32. Required: both accepted, data_out=0xAAAAAAAA, count stays 32, peek_data=0x55555555.
- Backpressure: buffer two words (count=64). Required: word_in_ready=0. Request 32, then word_in_ready=1 the next cycle and count=32.
- Edge cases:
  - At count=0, request L=0. Required: data_out_valid pulse with data_out=0.
  - Request L=40. Required: never accepted and state unchanged.
  - Assert nreset with 40 bits buffered. Required: count=0 and peek_data=0 the next cycle.
